// File: rtl/sparse_weight_loader_if.sv
// Stream-in / dense-row-out bundle for the sparse weight loader.
interface sparse_weight_loader_if #(
  parameter int unsigned COLS   = 24,
  parameter int unsigned W_BITS = 14
);
  logic                     s_valid;
  logic                     s_ready;
  logic [23:0]              s_data;
  logic                     s_last;
  logic                     wr_en;
  logic [7:0]               wr_row;
  logic [COLS*W_BITS-1:0]   wr_data;
  logic                     done;
  logic                     err;
  logic [7:0]               rows_loaded;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, wr_en, wr_row, wr_data, done, err, rows_loaded
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, wr_en, wr_row, wr_data, done, err, rows_loaded
  );
endinterface

// File: rtl/sparse_weight_loader.sv
// Expands a header/entry sparse stream into dense row writes, one row per header.
module sparse_weight_loader #(
  parameter int unsigned ROWS   = 12,
  parameter int unsigned COLS   = 24,
  parameter int unsigned W_BITS = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  sparse_weight_loader_if.slave bus
);
  localparam int unsigned DW      = COLS * W_BITS;
  localparam logic [7:0]  HDR_TAG = 8'hA5;
  localparam logic [7:0]  ROWS_B  = 8'(ROWS);
  localparam logic [7:0]  COLS_B  = 8'(COLS);

  typedef enum logic [1:0] {HDR, ENTRY, WRITE, DRAIN} state_t;

  state_t          state, state_next;
  logic [7:0]      row_q, row_next;
  logic [7:0]      cnt_q, cnt_next;
  logic [7:0]      loaded_q, loaded_next;
  logic [DW-1:0]   rbuf_q, rbuf_next;
  logic [DW-1:0]   wdata_q, wdata_next;
  logic [7:0]      wr_row_q, wr_row_next;
  logic            frame_end_q, frame_end_next;
  logic            err_q, err_next;
  logic            new_frame_q, new_frame_next;
  logic            wr_en_q, wr_en_next;
  logic            done_q, done_next;

  logic            ready;
  logic            accept;
  logic [7:0]      hi_field;
  logic [7:0]      f_row;
  logic [7:0]      f_nnz;
  logic [W_BITS-1:0] weight;
  logic            hdr_bad;
  logic            ent_bad;
  logic            unused_bits;

  // Word field decode; [23:16] is the tag for headers and the column for entries.
  assign ready       = !rst && (state != WRITE);
  assign accept      = bus.s_valid && ready;
  assign hi_field    = bus.s_data[23:16];
  assign f_row       = bus.s_data[15:8];
  assign f_nnz       = bus.s_data[7:0];
  assign weight      = W_BITS'($signed(bus.s_data[13:0]));
  assign unused_bits = ^bus.s_data[15:14];

  assign hdr_bad = (hi_field != HDR_TAG) || (f_row >= ROWS_B) || (f_nnz > COLS_B) ||
                   (bus.s_last && (f_nnz != 8'd0));
  assign ent_bad = (hi_field >= COLS_B) || (bus.s_last && (cnt_q > 8'd1));

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    row_next       = row_q;
    cnt_next       = cnt_q;
    loaded_next    = loaded_q;
    rbuf_next      = rbuf_q;
    wdata_next     = wdata_q;
    wr_row_next    = wr_row_q;
    frame_end_next = frame_end_q;
    err_next       = err_q;
    new_frame_next = new_frame_q;
    wr_en_next     = 1'b0;
    done_next      = 1'b0;

    case (state)
      HDR: begin
        if (accept) begin
          if (new_frame_q) begin
            err_next       = 1'b0;
            loaded_next    = 8'd0;
            new_frame_next = 1'b0;
          end
          if (hdr_bad) begin
            err_next = 1'b1;
            if (bus.s_last) begin
              state_next     = HDR;
              new_frame_next = 1'b1;
            end else begin
              state_next = DRAIN;
            end
          end else begin
            row_next       = f_row;
            cnt_next       = f_nnz;
            rbuf_next      = '0;
            frame_end_next = bus.s_last;
            state_next     = (f_nnz == 8'd0) ? WRITE : ENTRY;
          end
        end
      end
      ENTRY: begin
        if (accept) begin
          if (ent_bad) begin
            err_next = 1'b1;
            if (bus.s_last) begin
              state_next     = HDR;
              new_frame_next = 1'b1;
            end else begin
              state_next = DRAIN;
            end
          end else begin
            for (int c = 0; c < int'(COLS); c++) begin
              if (hi_field == 8'(c)) rbuf_next[c*W_BITS +: W_BITS] = weight;
            end
            cnt_next = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_next     = WRITE;
              frame_end_next = bus.s_last;
            end
          end
        end
      end
      WRITE: begin
        state_next = HDR;
      end
      DRAIN: begin
        if (accept && bus.s_last) begin
          state_next     = HDR;
          new_frame_next = 1'b1;
        end
      end
      default: state_next = HDR;
    endcase

    // Outputs for the WRITE cycle are captured on the edge that enters it.
    if (state_next == WRITE) begin
      wr_en_next  = 1'b1;
      wr_row_next = row_next;
      wdata_next  = rbuf_next;
      if (loaded_next != 8'hFF) loaded_next = loaded_next + 8'd1;
      done_next = frame_end_next && !err_next;
      if (done_next) new_frame_next = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HDR;
      row_q       <= 8'd0;
      cnt_q       <= 8'd0;
      loaded_q    <= 8'd0;
      rbuf_q      <= '0;
      wdata_q     <= '0;
      wr_row_q    <= 8'd0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
      new_frame_q <= 1'b1;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      row_q       <= row_next;
      cnt_q       <= cnt_next;
      loaded_q    <= loaded_next;
      rbuf_q      <= rbuf_next;
      wdata_q     <= wdata_next;
      wr_row_q    <= wr_row_next;
      frame_end_q <= frame_end_next;
      err_q       <= err_next;
      new_frame_q <= new_frame_next;
      wr_en_q     <= wr_en_next;
      done_q      <= done_next;
    end
  end

  assign bus.s_ready     = ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_row      = wr_row_q;
  assign bus.wr_data     = wdata_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.rows_loaded = loaded_q;
endmodule
